reaction_scoreboard: RTL and testbench

// - Listener on the reaction-game light outputs: watches start_led, win1_led and win2_led.
// - Measures each player's reaction time in clk cycles, from the start light rising to a win light rising.
// - Keeps per-player win counts, the last and best reaction time, and declares a match winner at a target score.
// - Sits beside the game on the same clk; drives the display/readout logic. Purely passive: never drives the game.

---
 rtl/reaction_pkg.sv | 28 ++
 rtl/rise_detect.sv | 26 ++
 rtl/reaction_scoreboard.sv | 151 +++++++++++++++
 tb/tb_reaction_scoreboard.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// rtl/reaction_pkg.sv - shared types and helpers for the reaction-game scoreboard
// Contents:
//   state_t  : scoreboard FSM states
//   winner_t : round / match winner codes driven on last_winner and match_winner
//   sat_inc  : saturating increment used by the timer and score counters
package reaction_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      TIMING     = 2'd1,
      RESULT     = 2'd2,
      MATCH_OVER = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10,
      WIN_TIE  = 2'b11
   } winner_t;

   // Operates on a 32-bit container so every counter width can share it;
   // callers pass their own all-ones ceiling and cast the result back down.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] ceiling);
      return (value >= ceiling) ? ceiling : value + 32'd1;
   endfunction

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - one-bit registered rising-edge detector
// Ports:
//   clk   in  1  system clock
//   reset in  1  asynchronous, active-high; clears the history register
//   d     in  1  level to watch, already synchronous to clk
//   rise  out 1  high for the cycle in which d is 1 and was 0 on the previous edge
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev <= 1'b0;
      end else begin
         prev <= d;
      end
   end

   assign rise = d & ~prev;

endmodule

// File: rtl/reaction_scoreboard.sv
// rtl/reaction_scoreboard.sv - passive reaction-time and match scoreboard for the reaction game
// Ports:
//   clk          in  1        system clock
//   reset        in  1        asynchronous, active-high
//   clear        in  1        synchronous match clear, overrides every state
//   start_led    in  1        game start light
//   win1_led     in  1        player-1 win light
//   win2_led     in  1        player-2 win light
//   score1       out SCORE_W  player-1 round wins (saturating)
//   score2       out SCORE_W  player-2 round wins (saturating)
//   last_time    out TIME_W   reaction time of the last decided round, in clk cycles
//   best_time    out TIME_W   fastest single-winner round this match, all-ones if none
//   last_winner  out 2        01 p1, 10 p2, 11 tie, 00 none
//   result_valid out 1        one-cycle pulse when a round result is committed
//   match_over   out 1        held once either score reaches WINS_TO_MATCH
//   match_winner out 2        01 / 10 while match_over, 00 otherwise
module reaction_scoreboard
   import reaction_pkg::*;
#(
   parameter int TIME_W        = 24,
   parameter int SCORE_W       = 4,
   parameter int WINS_TO_MATCH = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               start_led,
   input  logic               win1_led,
   input  logic               win2_led,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [TIME_W-1:0]  last_time,
   output logic [TIME_W-1:0]  best_time,
   output logic [1:0]         last_winner,
   output logic               result_valid,
   output logic               match_over,
   output logic [1:0]         match_winner
);

   localparam logic [31:0]        TIME_MAX  = 32'({TIME_W{1'b1}});
   localparam logic [31:0]        SCORE_MAX = 32'({SCORE_W{1'b1}});
   localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);

   state_t             state;
   logic [TIME_W-1:0]  timer;
   logic [TIME_W-1:0]  timer_next;
   logic [SCORE_W-1:0] score1_next;
   logic [SCORE_W-1:0] score2_next;
   logic               rise_start;
   logic               rise_win1;
   logic               rise_win2;

   rise_detect u_start_rise (.clk(clk), .reset(reset), .d(start_led), .rise(rise_start));
   rise_detect u_win1_rise  (.clk(clk), .reset(reset), .d(win1_led),  .rise(rise_win1));
   rise_detect u_win2_rise  (.clk(clk), .reset(reset), .d(win2_led),  .rise(rise_win2));

   // timer_next is also the cycle distance from the start-light edge to the
   // current edge, which is exactly the reaction time committed on a win.
   assign timer_next  = TIME_W'(sat_inc(32'(timer), TIME_MAX));
   assign score1_next = SCORE_W'(sat_inc(32'(score1), SCORE_MAX));
   assign score2_next = SCORE_W'(sat_inc(32'(score2), SCORE_MAX));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         timer        <= '0;
         score1       <= '0;
         score2       <= '0;
         last_time    <= '0;
         best_time    <= '1;
         last_winner  <= WIN_NONE;
         result_valid <= 1'b0;
         match_over   <= 1'b0;
         match_winner <= WIN_NONE;
      end else begin
         result_valid <= 1'b0;
         if (clear) begin
            state        <= IDLE;
            timer        <= '0;
            score1       <= '0;
            score2       <= '0;
            last_time    <= '0;
            best_time    <= '1;
            last_winner  <= WIN_NONE;
            match_over   <= 1'b0;
            match_winner <= WIN_NONE;
         end else begin
            case (state)
               IDLE: begin
                  if (rise_start) begin
                     state <= TIMING;
                     timer <= '0;
                  end
               end

               TIMING: begin
                  timer <= timer_next;
                  if (rise_win1 | rise_win2) begin
                     last_time    <= timer_next;
                     result_valid <= 1'b1;
                     state        <= RESULT;
                     if (rise_win1 & rise_win2) begin
                        last_winner <= WIN_TIE;
                     end else begin
                        if (rise_win1) begin
                           score1      <= score1_next;
                           last_winner <= WIN_P1;
                        end else begin
                           score2      <= score2_next;
                           last_winner <= WIN_P2;
                        end
                        if (timer_next < best_time) begin
                           best_time <= timer_next;
                        end
                     end
                  end else if (!start_led) begin
                     // The start light was high on entry and any earlier low
                     // would already have left TIMING, so low here is a fall.
                     state <= IDLE;
                  end
               end

               RESULT: begin
                  if (!win1_led && !win2_led) begin
                     if (score1 == WIN_SCORE) begin
                        state        <= MATCH_OVER;
                        match_over   <= 1'b1;
                        match_winner <= WIN_P1;
                     end else if (score2 == WIN_SCORE) begin
                        state        <= MATCH_OVER;
                        match_over   <= 1'b1;
                        match_winner <= WIN_P2;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end

               MATCH_OVER: begin
                  state <= MATCH_OVER;
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reaction_scoreboard.sv
// tb/tb_reaction_scoreboard.sv - scoreboard-driven bench for reaction_scoreboard
module tb_reaction_scoreboard;

   localparam int TIME_W  = 8;
   localparam int SCORE_W = 4;
   localparam int WINS    = 3;
   localparam int TMAX    = 255;
   localparam int SMAX    = 15;

   logic               clk = 1'b0;
   logic               reset;
   logic               clear;
   logic               start_led;
   logic               win1_led;
   logic               win2_led;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [TIME_W-1:0]  last_time;
   logic [TIME_W-1:0]  best_time;
   logic [1:0]         last_winner;
   logic               result_valid;
   logic               match_over;
   logic [1:0]         match_winner;

   reaction_scoreboard #(
      .TIME_W(TIME_W),
      .SCORE_W(SCORE_W),
      .WINS_TO_MATCH(WINS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .start_led(start_led),
      .win1_led(win1_led),
      .win2_led(win2_led),
      .score1(score1),
      .score2(score2),
      .last_time(last_time),
      .best_time(best_time),
      .last_winner(last_winner),
      .result_valid(result_valid),
      .match_over(match_over),
      .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int last_time;
      int winner;
      int s1;
      int s2;
      int best;
      int cyc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;

   int m_s1, m_s2, m_best, m_over, m_winner;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   task automatic check_cleared(input string pfx);
      check({pfx, "_score1"},       32'(score1),       0);
      check({pfx, "_score2"},       32'(score2),       0);
      check({pfx, "_last_time"},    32'(last_time),    0);
      check({pfx, "_best_time"},    32'(best_time),    TMAX);
      check({pfx, "_last_winner"},  32'(last_winner),  0);
      check({pfx, "_result_valid"}, 32'(result_valid), 0);
      check({pfx, "_match_over"},   32'(match_over),   0);
      check({pfx, "_match_winner"}, 32'(match_winner), 0);
   endtask

   task automatic model_clear();
      m_s1 = 0; m_s2 = 0; m_best = TMAX; m_over = 0; m_winner = 0;
   endtask

   // Start light, then after 'delay' cycles the chosen win light(s) with the
   // start light falling; expected result is queued at the moment of stimulus.
   task automatic drive_round(input int delay, input bit w1, input bit w2);
      exp_t e;
      int t;
      @(posedge clk); #1 start_led = 1'b1;
      repeat (delay) @(posedge clk);
      #1 win1_led = w1; win2_led = w2; start_led = 1'b0;
      if (m_over == 0) begin
         t = (delay > TMAX) ? TMAX : delay;
         if (w1 && w2) begin
            e.winner = 3;
         end else begin
            if (w1) begin
               m_s1 = (m_s1 < SMAX) ? m_s1 + 1 : SMAX;
               e.winner = 1;
            end else begin
               m_s2 = (m_s2 < SMAX) ? m_s2 + 1 : SMAX;
               e.winner = 2;
            end
            if (t < m_best) m_best = t;
         end
         e.last_time = t; e.s1 = m_s1; e.s2 = m_s2; e.best = m_best; e.cyc = cyc + 1;
         q.push_back(e);
         if (m_s1 == WINS) begin m_over = 1; m_winner = 1; end
         else if (m_s2 == WINS) begin m_over = 1; m_winner = 2; end
      end
      repeat (3) @(posedge clk);
      #1 win1_led = 1'b0; win2_led = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      model_clear();
   endtask

   always @(negedge clk) begin
      if (result_valid !== 1'b0) begin
         if (q.size() == 0) begin
            check("unexpected_result_valid", 32'(result_valid), 0);
         end else begin
            mon_e = q.pop_front();
            check("result_cycle", cyc,                 mon_e.cyc);
            check("last_time",    32'(last_time),      mon_e.last_time);
            check("last_winner",  32'(last_winner),    mon_e.winner);
            check("score1",       32'(score1),         mon_e.s1);
            check("score2",       32'(score2),         mon_e.s2);
            check("best_time",    32'(best_time),      mon_e.best);
         end
      end
   end

   initial begin
      reset = 1'b1; clear = 1'b0; start_led = 1'b0; win1_led = 1'b0; win2_led = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      @(posedge clk); #1 reset = 1'b0;
      repeat (4) @(posedge clk);

      drive_round(7, 1'b1, 1'b0);
      drive_round(4, 1'b1, 1'b1);
      drive_round(300, 1'b0, 1'b1);

      // aborted round: start rises and falls without any win light
      @(posedge clk); #1 start_led = 1'b1;
      repeat (5) @(posedge clk);
      #1 start_led = 1'b0;
      repeat (4) @(posedge clk);
      drive_round(6, 1'b1, 1'b0);
      @(negedge clk);
      check("after_abort_score1", 32'(score1), 2);
      check("after_abort_match_over", 32'(match_over), 0);

      pulse_clear();
      @(negedge clk);
      check_cleared("clear1");

      drive_round(3, 1'b0, 1'b1);
      drive_round(5, 1'b0, 1'b1);
      drive_round(9, 1'b0, 1'b1);
      @(negedge clk);
      check("match_over_set",   32'(match_over),   1);
      check("match_winner_p2",  32'(match_winner), 2);
      drive_round(4, 1'b0, 1'b1);
      @(negedge clk);
      check("ignored_score2",   32'(score2),       3);
      check("ignored_over",     32'(match_over),   1);

      pulse_clear();
      @(negedge clk);
      check_cleared("clear2");

      drive_round(5, 1'b1, 1'b0);
      @(negedge clk);
      check("pre_reset_score1", 32'(score1), 1);

      // reset in the middle of a timed round, win light rises during reset
      @(posedge clk); #1 start_led = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_cleared("mid_reset");
      @(posedge clk); #1 win1_led = 1'b1; start_led = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1 win1_led = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("post_reset");

      drive_round(8, 1'b0, 1'b1);

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("pending_results", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
